rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter with grant locking. Shares one resource (bus, encoder input slot, shared register) among four requesters. Produces a registered one-hot grant plus an encoded grant index and valid flag, the same x/y/V-style encoding as the 4-input priority encoder. Rotating priority replaces fixed priority so no requester starves.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles before forced rotation. Used only when `RR_HOLD_LIMIT_EN` is defined. Legal range 2..255.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request lines; `req[i]`=1 means requester i wants the resource. Level-sensitive, may change any cycle.
- `gnt`  output  4  registered one-hot grant; all zero when idle.
- `gnt_id`  output  2  binary index of the granted requester.
- `gnt_v`  output  1  1 when any grant is active (`gnt != 0`).

## Operation
- State: `IDLE`, `BUSY`. Registers: `owner[1:0]`, `last[1:0]` (last granted index), `hold_cnt[7:0]` (present only with macro).
- Reset values: state `IDLE`, `gnt`=4'b0000, `gnt_id`=2'b00, `gnt_v`=0, `owner`=0, `last`=3 (first search starts at requester 0), `hold_cnt`=0.
- Rotating search: priority order is `last+1, last+2, last+3, last` (mod 4). The winner is the first index in that order with `req`=1.
- `IDLE`: if `req`=0, stay. Otherwise grant the winner next edge:
  - `owner`=`last`=winner; `gnt`=one-hot(winner); `gnt_id`=winner; `gnt_v`=1.
  - Go to `BUSY`.
- `BUSY`, owner still requesting (`req[owner]`=1): keep the grant unchanged (lock), unless the hold limit forces rotation (see Configuration).
- `BUSY`, owner dropped (`req[owner]`=0):
  - Other requests present: grant the next winner on the same edge, with no idle bubble.
  - No requests: return to `IDLE`; `gnt`=0, `gnt_v`=0.
  - `gnt_id` keeps its last value while idle.
- Encoding invariant: `gnt_v`=1 implies `gnt`=one-hot(`gnt_id`). `gnt_v`=0 implies `gnt`=0.
- At most one grant bit is set, in every cycle.

## Timing
- Latency from request to grant is 1 cycle: `req` sampled at edge N gives `gnt` valid after edge N.
- Release to next grant is 1 cycle: owner drops `req` before edge N, and the new owner is granted after edge N.
- Requesters must treat the resource as theirs only while their `gnt` bit is 1. Dropping `req` releases it at the next edge.
- Simultaneous requests are resolved purely by rotating priority from `last`.
- Reset mid-grant: at the reset edge, outputs return to reset values and any held grant is lost. Arbitration resumes from requester 0 on the first edge with `rst`=0.
- Outputs depend on registers only; there is no combinational path from `req` to `gnt`.

## Configuration
- Macro: `RR_HOLD_LIMIT_EN`.
- Defined:
  - `hold_cnt` is cleared on each new grant and increments every `BUSY` cycle.
  - When `hold_cnt`=`HOLD_MAX-1` and any other requester is active, the next edge rotates the grant to the winner, even if `req[owner]`=1.
  - If no other requester is active, the owner keeps the grant and `hold_cnt` restarts at 0.
- Undefined:
  - `hold_cnt` is not instantiated and `HOLD_MAX` is ignored.
  - The owner keeps the grant indefinitely while `req[owner]`=1.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles -> `gnt`=0000, `gnt_v`=0, `gnt_id`=00 every cycle.
- Reset, then `req`=4'b1111 held, with each owner dropping its bit for one cycle after receiving the grant -> grant sequence 0001, 0010, 0100, 1000, 0001; `gnt_id` 0,1,2,3,0; no idle cycle between grants.
- `req`=4'b0100 only -> `gnt`=0100 and `gnt_id`=10 one cycle later. Drop `req` -> `gnt`=0000 and `gnt_v`=0 the next cycle.
- Macro undefined, `req`=4'b0011 held for 20 cycles -> `gnt`=0001 for all 20 cycles (lock).
- Macro defined, `HOLD_MAX`=4, `req`=4'b0011 held -> `gnt` alternates 0001 ×4 cycles, 0010 ×4 cycles, 0001 ×4 cycles.
- Assert `rst` while `gnt`=1000, then apply `req`=4'b1001 -> `gnt`=0000 after the reset edge; first grant after reset is 0001, not 1000.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Purpose : four-requester round-robin arbiter with grant locking and optional hold limit.
// Latency : one cycle from req sampled to registered gnt; owner release to next grant also one cycle.
// Backpr. : level-sensitive req, no backpressure; a requester holds the resource only while its gnt bit is 1.
//
// Ports:
//   clk     - single clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   req     - request lines, req[i]=1 means requester i wants the resource
//   gnt     - registered one-hot grant, all zero when idle
//   gnt_id  - binary index of the granted requester (keeps last value while idle)
//   gnt_v   - 1 while any grant is active
//
// Optional feature macro: RR_HOLD_LIMIT_EN
//   Defined   : an owner that keeps requesting is forced to rotate after HOLD_MAX
//               consecutive grant cycles, provided another requester is waiting.
//   Undefined : the owner keeps the grant for as long as it keeps requesting;
//               HOLD_MAX is only range-checked.

module rr_arbiter4 #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_v
);

   // Hold limit counter is 8 bits wide, so the limit must fit in it.
   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("rr_arbiter4: HOLD_MAX must be in 2..255");
   end

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q,  state_d;
   logic [1:0] owner_q,  owner_d;
   logic [1:0] last_q,   last_d;
   logic [3:0] gnt_q,    gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       gnt_v_q,  gnt_v_d;

   // Rotating-priority search result.
   logic       win_found;
   logic [1:0] win_id;
   logic [3:0] win_oh;
   logic [1:0] cand;

   logic       owner_req;
   logic       do_grant;
   logic       do_release;

`ifdef RR_HOLD_LIMIT_EN
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       hold_expired;
   logic       others_req;
`endif

   // ------------------------------------------------------------------
   // Winner search: scan last+1, last+2, last+3, last (mod 4). The 2-bit
   // add wraps naturally. In BUSY last==owner, so the owner is checked
   // last and any other active requester wins ahead of it.
   // ------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_id    = last_q;
      cand      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign win_oh    = 4'b0001 << win_id;
   assign owner_req = req[owner_q];

`ifdef RR_HOLD_LIMIT_EN
   assign others_req   = |(req & ~(4'b0001 << owner_q));
   assign hold_expired = (hold_cnt_q == 8'(HOLD_MAX - 1));
`endif

   // ------------------------------------------------------------------
   // Next-state / next-output logic. The case statement only decides
   // whether to grant the current winner or release to idle; the grant
   // load itself is shared below so every grant path updates the same
   // set of registers.
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      gnt_v_d    = gnt_v_q;
      do_grant   = 1'b0;
      do_release = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (win_found) begin
               do_grant = 1'b1;
            end
         end

         BUSY: begin
            if (owner_req) begin
`ifdef RR_HOLD_LIMIT_EN
               if (hold_expired) begin
                  if (others_req) begin
                     // Forced rotation: owner still wants it, but someone
                     // else has waited long enough.
                     do_grant = 1'b1;
                  end else begin
                     // Nobody to hand over to; start a fresh hold window.
                     hold_cnt_d = 8'd0;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
`endif
               // Without the hold limit the grant is simply locked.
            end else if (win_found) begin
               // Owner released and another requester is waiting: hand
               // over on this edge with no idle bubble.
               do_grant = 1'b1;
            end else begin
               do_release = 1'b1;
            end
         end

         default: begin
            do_release = 1'b1;
         end
      endcase

      if (do_grant) begin
         state_d  = BUSY;
         owner_d  = win_id;
         last_d   = win_id;
         gnt_d    = win_oh;
         gnt_id_d = win_id;
         gnt_v_d  = 1'b1;
`ifdef RR_HOLD_LIMIT_EN
         hold_cnt_d = 8'd0;
`endif
      end else if (do_release) begin
         // gnt_id intentionally keeps its last value while idle.
         state_d = IDLE;
         gnt_d   = 4'b0000;
         gnt_v_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State and output registers. last resets to 3 so the first search
   // after reset starts at requester 0.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 2'd0;
         last_q   <= 2'd3;
         gnt_q    <= 4'b0000;
         gnt_id_q <= 2'd0;
         gnt_v_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         gnt_v_q  <= gnt_v_d;
      end
   end

`ifdef RR_HOLD_LIMIT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= 8'd0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   // Outputs come straight from registers: no combinational req->gnt path.
   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign gnt_v  = gnt_v_q;

   // Encoding invariants of the grant outputs.
   a_gnt_onehot : assert property (@(posedge clk) disable iff (rst)
      gnt_v |-> (gnt == (4'b0001 << gnt_id)));
   a_gnt_idle   : assert property (@(posedge clk) disable iff (rst)
      !gnt_v |-> (gnt == 4'b0000));

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       v;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_v;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   rr_arbiter4 #(.HOLD_MAX(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .gnt_v  (gnt_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst = 1'b0;
   endtask

   // Reset values, reset dominating active requests, then idle with no requests.
   task automatic test_reset;
      exp_t e;
      exp_t got;
      rst = 1'b1;
      req = 4'b1111;
      sb_q.push_back('{4'b0000, 2'd0, 1'b0});
      tick();
      got = {gnt, gnt_id, gnt_v};
      e   = sb_q.pop_front();
      n_checks++;
      if (got !== e)
         $display("FAIL reset_state: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                  got.gnt, got.id, got.v, e.gnt, e.id, e.v);
      if (got !== e) n_fail++;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req = 4'b0000;
         sb_q.push_back('{4'b0000, 2'd0, 1'b0});
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL idle_cycle%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
   endtask

   // All four requesting, each owner dropping its bit for one cycle: pure rotation, no bubble.
   task automatic test_rotation;
      logic [3:0] reqs [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_t       exps [5] = '{'{4'b0001, 2'd0, 1'b1}, '{4'b0010, 2'd1, 1'b1},
                               '{4'b0100, 2'd2, 1'b1}, '{4'b1000, 2'd3, 1'b1},
                               '{4'b0001, 2'd0, 1'b1}};
      exp_t e;
      exp_t got;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         req = reqs[k];
         sb_q.push_back(exps[k]);
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL rotation_step%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
   endtask

   // Single requester grant/release, gnt_id held while idle, and priority resuming from last.
   task automatic test_single;
      logic [3:0] reqs [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0010};
      exp_t       exps [6] = '{'{4'b0100, 2'd2, 1'b1}, '{4'b0000, 2'd2, 1'b0},
                               '{4'b0000, 2'd2, 1'b0}, '{4'b0001, 2'd0, 1'b1},
                               '{4'b0001, 2'd0, 1'b1}, '{4'b0010, 2'd1, 1'b1}};
      exp_t e;
      exp_t got;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         req = reqs[k];
         sb_q.push_back(exps[k]);
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL single_step%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
   endtask

`ifdef RR_HOLD_LIMIT_EN
   // HOLD_MAX=4 with two requesters held: grant alternates every four cycles.
   task automatic test_hold_limit;
      exp_t e;
      exp_t got;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         req = 4'b0011;
         if (k < 4 || k >= 8) sb_q.push_back('{4'b0001, 2'd0, 1'b1});
         else                 sb_q.push_back('{4'b0010, 2'd1, 1'b1});
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
   endtask
`else
   // Owner that keeps requesting keeps the grant indefinitely.
   task automatic test_lock;
      exp_t e;
      exp_t got;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         req = 4'b0011;
         sb_q.push_back('{4'b0001, 2'd0, 1'b1});
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL lock_cycle%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
   endtask
`endif

   // Reset while requester 3 holds the grant; arbitration restarts from requester 0.
   task automatic test_reset_mid_grant;
      logic [3:0] reqs [5] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
      logic       rsts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_t       exps [5] = '{'{4'b1000, 2'd3, 1'b1}, '{4'b1000, 2'd3, 1'b1},
                               '{4'b0000, 2'd0, 1'b0}, '{4'b0001, 2'd0, 1'b1},
                               '{4'b0001, 2'd0, 1'b1}};
      exp_t e;
      exp_t got;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         req = reqs[k];
         rst = rsts[k];
         sb_q.push_back(exps[k]);
         tick();
         got = {gnt, gnt_id, gnt_v};
         e   = sb_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_step%0d: gnt=%b gnt_id=%0d gnt_v=%b required gnt=%b gnt_id=%0d gnt_v=%b",
                     k, got.gnt, got.id, got.v, e.gnt, e.id, e.v);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      test_reset();
      test_rotation();
      test_single();
`ifdef RR_HOLD_LIMIT_EN
      test_hold_limit();
`else
      test_lock();
`endif
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
